multicycle_datapath: RTL and testbench

//  Multi-cycle MIPS-subset core: datapath plus internal sequencing FSM.

---
 rtl/mc_pkg.sv | 42 ++++
 rtl/mc_regfile.sv | 28 ++
 rtl/multicycle_datapath.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared state, ALU-op and instruction-encoding definitions for the multicycle MIPS-subset core.
package mc_pkg;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;
   typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // bne is only a valid opcode when the build enables it.
   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn,
                                     input logic bne_en);
      case (op)
         OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
         OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
         OP_BNE: return bne_en;
         default: return 1'b0;
      endcase
   endfunction

   function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
      case (fn)
         FN_SUB: return SUB;
         FN_AND: return AND;
         FN_OR:  return OR;
         FN_SLT: return SLT;
         default: return ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32 x N register file: two asynchronous read ports, one synchronous write port, $0 hardwired to zero.
module mc_regfile #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic [4:0]   ra1,
   input  logic [4:0]   ra2,
   output logic [N-1:0] rd1,
   output logic [N-1:0] rd2,
   input  logic         we,
   input  logic [4:0]   wa,
   input  logic [N-1:0] wd
);

   logic [N-1:0] regs [32];

   // NOTE: the storage array is deliberately not reset; software initialises registers
   // before use, and leaving it unreset lets the array map onto plain RAM/flop cells.
   always_ff @(posedge clk) begin
      if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core with a single shared req/ready memory port and sequencing FSM.
// Define MULTICYCLE_BNE_EN to decode opcode 000101 (bne); otherwise it traps as illegal.
module multicycle_datapath
   import mc_pkg::*;
#(
   parameter int            N        = 32,
   parameter logic [N-1:0]  RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata,
   input  logic         mem_ready,
   output logic [N-1:0] pc,
   output logic         retire,
   output logic         illegal
);

`ifdef MULTICYCLE_BNE_EN
   localparam logic BNE_EN = 1'b1;
`else
   localparam logic BNE_EN = 1'b0;
`endif

   state_t       state;
   logic [31:0]  ir;
   logic [N-1:0] a_reg, b_reg, alu_out, mdr;

   logic [5:0]   opcode, funct;
   logic [4:0]   rs, rt, rd;
   logic [N-1:0] imm_sext, imm_word, pc_plus4;

   logic [N-1:0] rf_rd1, rf_rd2, rf_wd;
   logic [4:0]   rf_wa;
   logic         rf_we;

   alu_op_t      alu_op;
   logic [N-1:0] alu_b, alu_result;
   logic         branch_taken;

   assign opcode   = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign funct    = ir[5:0];
   assign imm_sext = {{(N-16){ir[15]}}, ir[15:0]};
   assign imm_word = {imm_sext[N-3:0], 2'b00};
   assign pc_plus4 = pc + N'(4);

   mc_regfile #(.N(N)) u_rf (
      .clk (clk),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rf_rd1),
      .rd2 (rf_rd2),
      .we  (rf_we),
      .wa  (rf_wa),
      .wd  (rf_wd)
   );

   // R-type writes rd; addi and lw write rt.
   assign rf_we = (state == WB);
   assign rf_wa = (opcode == OP_RTYPE) ? rd : rt;
   assign rf_wd = (opcode == OP_LW) ? mdr : alu_out;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned
   // (an unassigned path would infer a latch).
   always_comb begin
      alu_op = ADD;
      alu_b  = imm_sext;
      if (opcode == OP_RTYPE) begin
         alu_op = funct_to_alu(funct);
         alu_b  = b_reg;
      end
      case (alu_op)
         ADD:     alu_result = a_reg + alu_b;
         SUB:     alu_result = a_reg - alu_b;
         AND:     alu_result = a_reg & alu_b;
         OR:      alu_result = a_reg | alu_b;
         SLT:     alu_result = {{(N-1){1'b0}}, $signed(a_reg) < $signed(alu_b)};
         default: alu_result = '0;
      endcase
   end

   assign branch_taken = (a_reg == b_reg) ^ (opcode == OP_BNE);

   // Store completion depends on mem_ready in the same cycle, so retire is decoded, not registered.
   always_comb begin
      retire = 1'b0;
      case (state)
         EXEC:    retire = opcode inside {OP_BEQ, OP_BNE, OP_J};
         MEM:     retire = mem_ready && opcode == OP_SW;
         WB:      retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   assign mem_addr  = (state == MEM) ? alu_out : pc;
   assign mem_wdata = b_reg;

   // NOTE: all state here is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         illegal <= 1'b0;
         ir      <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         alu_out <= '0;
         mdr     <= '0;
      end else begin
         case (state)
            FETCH: begin
               // The first cycle out of reset only raises the request.
               if (!mem_req) begin
                  mem_req <= 1'b1;
               end else if (mem_ready) begin
                  ir      <= mem_rdata[31:0];
                  pc      <= pc_plus4;
                  mem_req <= 1'b0;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               a_reg   <= rf_rd1;
               b_reg   <= rf_rd2;
               alu_out <= pc + imm_word;
               if (is_legal(opcode, funct, BNE_EN)) begin
                  state <= EXEC;
               end else begin
                  illegal <= 1'b1;
                  state   <= ERR;
               end
            end
            EXEC: begin
               case (opcode)
                  OP_RTYPE, OP_ADDI: begin
                     alu_out <= alu_result;
                     state   <= WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_out <= alu_result;
                     mem_req <= 1'b1;
                     mem_we  <= (opcode == OP_SW);
                     state   <= MEM;
                  end
                  OP_BEQ, OP_BNE: begin
                     if (branch_taken) pc <= alu_out;
                     mem_req <= 1'b1;
                     state   <= FETCH;
                  end
                  OP_J: begin
                     pc      <= {pc[N-1:28], ir[25:0], 2'b00};
                     mem_req <= 1'b1;
                     state   <= FETCH;
                  end
                  default: begin
                     illegal <= 1'b1;
                     state   <= ERR;
                  end
               endcase
            end
            MEM: begin
               if (mem_ready) begin
                  mem_we <= 1'b0;
                  if (opcode == OP_LW) begin
                     mdr     <= mem_rdata;
                     mem_req <= 1'b0;
                     state   <= WB;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            WB: begin
               mem_req <= 1'b1;
               state   <= FETCH;
            end
            default: begin
               // ERR (and any unused encoding) parks here until reset.
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               illegal <= 1'b1;
               state   <= ERR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: unified memory model, instruction table, scoreboards.
module tb_multicycle_datapath;

   localparam int N = 32;

   localparam logic [5:0] T_ADDI = 6'b001000, T_LW = 6'b100011, T_SW = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100, T_BNE = 6'b000101, T_J  = 6'b000010;
   localparam logic [5:0] T_ADD  = 6'b100000, T_SUB = 6'b100010, T_AND = 6'b100100;
   localparam logic [5:0] T_OR   = 6'b100101, T_SLT = 6'b101010;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          lat;
      int          waits;
      logic [31:0] pc_after;
      bit          is_st;
      logic [31:0] st_addr;
      logic [31:0] st_data;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } st_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         mem_req, mem_we, mem_ready, retire, illegal;
   logic [N-1:0] mem_addr, mem_wdata, mem_rdata, pc;

   logic [31:0]  prog [0:1023];
   logic [31:0]  dmem [0:1023];
   bit           st_valid [0:1023];
   int           cycle;
   int           hold_until;
   bit           block_st;
   int           st_count;
   logic [31:0]  last_st_addr, last_st_data;

   int           n_pass, n_total;
   vec_t         vecs[$];
   logic [31:0]  exp_pc_q[$];
   st_t          exp_st_q[$];

   multicycle_datapath #(.N(N), .RESET_PC('0)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .retire    (retire),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Unified memory: stored words shadow the program image.
   assign mem_rdata = st_valid[mem_addr[11:2]] ? dmem[mem_addr[11:2]] : prog[mem_addr[11:2]];
   assign mem_ready = mem_req && (cycle >= hold_until) && !(block_st && mem_we);

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (reset && mem_req && mem_ready && mem_we) begin
         dmem[mem_addr[11:2]]     <= mem_wdata;
         st_valid[mem_addr[11:2]] <= 1'b1;
         st_count                 <= st_count + 1;
         last_st_addr             <= mem_addr;
         last_st_data             <= mem_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] r_ins(input int rs_i, input int rt_i, input int rd_i,
                                         input logic [5:0] fn);
      return {6'b000000, 5'(rs_i), 5'(rt_i), 5'(rd_i), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs_i, input int rt_i,
                                         input logic [15:0] imm);
      return {op, 5'(rs_i), 5'(rt_i), imm};
   endfunction

   task automatic add_vec(input logic [31:0] a, input logic [31:0] ins, input int lat,
                          input int waits, input logic [31:0] nxt, input bit st,
                          input logic [31:0] sa, input logic [31:0] sd);
      vec_t v;
      v.pc = a; v.instr = ins; v.lat = lat; v.waits = waits; v.pc_after = nxt;
      v.is_st = st; v.st_addr = sa; v.st_data = sd;
      vecs.push_back(v);
   endtask

   task automatic wait_req(input string name);
      int k = 0;
      while (!mem_req && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      check(name, {31'd0, mem_req}, 32'd1);
   endtask

   task automatic wait_illegal(input string name);
      int k = 0;
      while (!illegal && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      check(name, {31'd0, illegal}, 32'd1);
   endtask

   initial begin
      vec_t        v;
      int          n;
      bit          done;
      int          prev_st;
      logic [31:0] exp_pc;
      st_t         exp_st;
      logic [31:0] ill_pc;

      reset = 1'b0;
      for (int i = 0; i < 1024; i++) prog[i] = 32'h0;

      //       pc      instruction                         lat wt next     st  addr   data
      add_vec(32'h000, i_ins(T_ADDI, 0, 1, 16'd7),         4, 0, 32'h004, 0, 0, 0);
      add_vec(32'h004, i_ins(T_ADDI, 0, 2, 16'd5),         4, 0, 32'h008, 0, 0, 0);
      add_vec(32'h008, r_ins(1, 2, 3, T_ADD),              4, 3, 32'h00C, 0, 0, 0);
      add_vec(32'h00C, r_ins(1, 2, 4, T_SUB),              4, 0, 32'h010, 0, 0, 0);
      add_vec(32'h010, i_ins(T_BEQ, 1, 1, 16'd2),          3, 0, 32'h01C, 0, 0, 0);
      add_vec(32'h01C, i_ins(T_SW, 0, 3, 16'h40),          4, 0, 32'h020, 1, 32'h40, 32'd12);
      add_vec(32'h020, i_ins(T_LW, 0, 6, 16'h40),          5, 0, 32'h024, 0, 0, 0);
      add_vec(32'h024, i_ins(T_SW, 0, 6, 16'h44),          4, 0, 32'h028, 1, 32'h44, 32'd12);
      add_vec(32'h028, {T_J, 26'h100},                     3, 0, 32'h400, 0, 0, 0);
      add_vec(32'h400, i_ins(T_SW, 0, 4, 16'h48),          4, 2, 32'h404, 1, 32'h48, 32'd2);
      add_vec(32'h404, r_ins(2, 1, 7, T_SLT),              4, 0, 32'h408, 0, 0, 0);
      add_vec(32'h408, i_ins(T_ADDI, 0, 9, 16'hFFFF),      4, 0, 32'h40C, 0, 0, 0);
      add_vec(32'h40C, r_ins(9, 1, 10, T_SLT),             4, 0, 32'h410, 0, 0, 0);
      add_vec(32'h410, r_ins(1, 9, 11, T_SLT),             4, 0, 32'h414, 0, 0, 0);
      add_vec(32'h414, r_ins(1, 2, 12, T_AND),             4, 0, 32'h418, 0, 0, 0);
      add_vec(32'h418, r_ins(1, 2, 13, T_OR),              4, 0, 32'h41C, 0, 0, 0);
      add_vec(32'h41C, i_ins(T_ADDI, 0, 0, 16'd9),         4, 0, 32'h420, 0, 0, 0);
      add_vec(32'h420, i_ins(T_BEQ, 1, 2, 16'd5),          3, 0, 32'h424, 0, 0, 0);
      add_vec(32'h424, i_ins(T_SW, 0, 7, 16'h4C),          4, 0, 32'h428, 1, 32'h4C, 32'd1);
      add_vec(32'h428, i_ins(T_SW, 0, 10, 16'h50),         4, 0, 32'h42C, 1, 32'h50, 32'd1);
      add_vec(32'h42C, i_ins(T_SW, 0, 11, 16'h54),         4, 0, 32'h430, 1, 32'h54, 32'd0);
      add_vec(32'h430, i_ins(T_SW, 0, 12, 16'h58),         4, 0, 32'h434, 1, 32'h58, 32'd5);
      add_vec(32'h434, i_ins(T_SW, 0, 13, 16'h5C),         4, 0, 32'h438, 1, 32'h5C, 32'd7);
      add_vec(32'h438, i_ins(T_SW, 0, 0, 16'h60),          4, 0, 32'h43C, 1, 32'h60, 32'd0);
      add_vec(32'h43C, i_ins(T_SW, 0, 9, 16'h64),          4, 0, 32'h440, 1, 32'h64, 32'hFFFF_FFFF);
      add_vec(32'h440, r_ins(0, 1, 15, T_SUB),             4, 0, 32'h444, 0, 0, 0);
      add_vec(32'h444, i_ins(T_SW, 0, 15, 16'h68),         4, 0, 32'h448, 1, 32'h68, 32'hFFFF_FFF9);
`ifdef MULTICYCLE_BNE_EN
      add_vec(32'h448, i_ins(T_BNE, 1, 2, 16'd1),          3, 0, 32'h450, 0, 0, 0);
      ill_pc = 32'h450;
`else
      ill_pc = 32'h448;
`endif
      for (int i = 0; i < vecs.size(); i++) prog[vecs[i].pc[11:2]] = vecs[i].instr;
      prog[32'h14 >> 2]  = i_ins(T_ADDI, 0, 1, 16'd99);
      prog[32'h18 >> 2]  = i_ins(T_ADDI, 0, 1, 16'd99);
      prog[32'h448 >> 2] = i_ins(T_BNE, 1, 2, 16'd1);
      prog[32'h44C >> 2] = i_ins(T_ADDI, 0, 1, 16'd99);
      prog[32'h450 >> 2] = 32'hFC00_0000;

      // Reset state, then reset while a fetch is stalled with mem_req high.
      hold_until = 1 << 30;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we",  {31'd0, mem_we},  32'd0);
      check("rst_retire",  {31'd0, retire},  32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_pc",      pc,               32'd0);
      @(negedge clk) reset = 1'b1;
      wait_req("first_fetch_req");
      repeat (2) @(posedge clk);
      #1;
      check("stalled_fetch_req",  {31'd0, mem_req}, 32'd1);
      check("stalled_fetch_addr", mem_addr,         32'd0);
      #2 reset = 1'b0;
      #1;
      check("midfetch_rst_req",     {31'd0, mem_req}, 32'd0);
      check("midfetch_rst_pc",      pc,               32'd0);
      check("midfetch_rst_illegal", {31'd0, illegal}, 32'd0);
      hold_until = 0;
      @(negedge clk) reset = 1'b1;
      wait_req("run_fetch_req");

      // Table run: each entry starts in its FETCH cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         exp_pc_q.push_back(v.pc_after);
         if (v.is_st) begin
            exp_st.addr = v.st_addr;
            exp_st.data = v.st_data;
            exp_st_q.push_back(exp_st);
         end
         prev_st    = st_count;
         hold_until = cycle + v.waits;
         check($sformatf("fetch_addr[%0d]", i), mem_addr, v.pc);
         n    = 0;
         done = 1'b0;
         while (!done && n < 40) begin
            n++;
            if (retire) begin
               done = 1'b1;
            end else begin
               if (n <= v.waits) begin
                  check($sformatf("stall_req[%0d]", i),  {31'd0, mem_req}, 32'd1);
                  check($sformatf("stall_addr[%0d]", i), mem_addr,         v.pc);
               end
               @(posedge clk); #1;
            end
         end
         check($sformatf("retire_seen[%0d]", i), {31'd0, done}, 32'd1);
         check($sformatf("latency[%0d]", i), n, v.lat + v.waits);
         @(posedge clk); #1;
         check($sformatf("retire_pulse[%0d]", i), {31'd0, retire}, 32'd0);
         exp_pc = exp_pc_q.pop_front();
         check($sformatf("pc_after[%0d]", i), pc, exp_pc);
         if (v.is_st) begin
            exp_st = exp_st_q.pop_front();
            check($sformatf("st_count[%0d]", i), st_count, prev_st + 1);
            check($sformatf("st_addr[%0d]", i),  last_st_addr, exp_st.addr);
            check($sformatf("st_data[%0d]", i),  last_st_data, exp_st.data);
         end else begin
            check($sformatf("no_store[%0d]", i), st_count, prev_st);
         end
      end

      // Trap: bne (default build) or opcode 111111 (bne build).
      check("trap_fetch_addr", mem_addr, ill_pc);
      wait_illegal("trap_illegal");
      repeat (6) begin
         @(posedge clk); #1;
         check("trap_mem_req", {31'd0, mem_req}, 32'd0);
         check("trap_pc",      pc,               ill_pc + 32'd4);
         check("trap_retire",  {31'd0, retire},  32'd0);
      end
      #2 reset = 1'b0;
      #1;
      check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
      check("trap_rst_pc",      pc,               32'd0);

      // Opcode 111111 at the reset vector.
      prog[0] = 32'hFC00_0000;
      @(negedge clk) reset = 1'b1;
      wait_req("ill_fetch_req");
      check("ill_fetch_addr", mem_addr, 32'd0);
      wait_illegal("ill_illegal");
      repeat (5) begin
         @(posedge clk); #1;
         check("ill_mem_req", {31'd0, mem_req}, 32'd0);
         check("ill_pc",      pc,               32'd4);
      end

      // Reset while a store is held off by mem_ready: no write, no retire.
      reset = 1'b0;
      prog[0]  = vecs[0].instr;
      block_st = 1'b1;
      @(negedge clk) reset = 1'b1;
      n = 0;
      while (!mem_we && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check("blk_st_we",     {31'd0, mem_we},  32'd1);
      check("blk_st_addr",   mem_addr,         32'h40);
      check("blk_st_data",   mem_wdata,        32'd12);
      check("blk_st_retire", {31'd0, retire},  32'd0);
      prev_st = st_count;
      #2 reset = 1'b0;
      #1;
      check("midst_rst_req", {31'd0, mem_req}, 32'd0);
      check("midst_rst_we",  {31'd0, mem_we},  32'd0);
      check("midst_retire",  {31'd0, retire},  32'd0);
      @(posedge clk); #1;
      check("midst_no_write", st_count, prev_st);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
